// File: rtl/circuit5_vector_driver.sv
// Exhaustive 3-input sweep driver for circuit_5.
// Steps {a,b,c} 0..7, samples o per vector, grades against a golden table.
module circuit5_vector_driver #(
  parameter int unsigned SETTLE_CYCLES = 4,
  parameter logic [7:0]  GOLDEN        = 8'h51
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       o_in,
  output logic       a,
  output logic       b,
  output logic       c,
  output logic       busy,
  output logic       done,
  output logic [7:0] resp,
  output logic       pass,
  output logic [3:0] mismatch_cnt
);

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    SAMPLE,
    FINISH
  } state_t;

  localparam logic [7:0] LP_LAST = 8'(SETTLE_CYCLES - 1);

  state_t     r_state;
  state_t     w_next;
  logic [2:0] r_vec;
  logic [7:0] r_cnt;
  logic [7:0] r_resp;
  logic       r_busy;
  logic       r_done;
  logic       r_pass;
  logic [3:0] r_mm;

  logic w_load;
  logic w_tick;
  logic w_sample;
  logic w_finish;

  function automatic logic [3:0] f_popcnt(input logic [7:0] v);
    logic [3:0] s;
    s = 4'd0;
    for (int i = 0; i < 8; i++) s = s + 4'(v[i]);
    return s;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    if (start) w_next = SETTLE;
      SETTLE:  if (r_cnt == LP_LAST) w_next = SAMPLE;
      SAMPLE:  w_next = (r_vec == 3'd7) ? FINISH : SETTLE;
      FINISH:  w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    w_load   = 1'b0;
    w_tick   = 1'b0;
    w_sample = 1'b0;
    w_finish = 1'b0;
    unique case (r_state)
      IDLE:    w_load   = start;
      SETTLE:  w_tick   = 1'b1;
      SAMPLE:  w_sample = 1'b1;
      FINISH:  w_finish = 1'b1;
      default: ;
    endcase
  end

  // The applied vector is r_vec itself, so it keeps 3'b111 after a sweep.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_vec  <= 3'd0;
      r_cnt  <= 8'd0;
      r_resp <= 8'd0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
      r_pass <= 1'b0;
      r_mm   <= 4'd0;
    end else begin
      r_done <= 1'b0;
      if (w_load) begin
        r_vec  <= 3'd0;
        r_cnt  <= 8'd0;
        r_busy <= 1'b1;
        r_resp <= 8'd0;
        r_pass <= 1'b0;
        r_mm   <= 4'd0;
      end
      if (w_tick) r_cnt <= r_cnt + 8'd1;
      if (w_sample) begin
        r_resp[r_vec] <= o_in;
        if (r_vec != 3'd7) begin
          r_vec <= r_vec + 3'd1;
          r_cnt <= 8'd0;
        end
      end
      if (w_finish) begin
        r_done <= 1'b1;
        r_busy <= 1'b0;
        r_pass <= (r_resp == GOLDEN);
        r_mm   <= f_popcnt(r_resp ^ GOLDEN);
      end
    end
  end

  assign {a, b, c}    = r_vec;
  assign busy         = r_busy;
  assign done         = r_done;
  assign resp         = r_resp;
  assign pass         = r_pass;
  assign mismatch_cnt = r_mm;

endmodule

// File: tb/tb_circuit5_vector_driver.sv
// Scoreboard bench for circuit5_vector_driver.
// Two instances: default settle time and SETTLE_CYCLES=1.
module tb_circuit5_vector_driver;

  localparam logic [7:0] GOLD = 8'h51;

  typedef struct {
    logic [7:0] resp;
    logic       pass;
    logic [3:0] mm;
    int         cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic start1 = 1'b0;
  logic [1:0] mode = 2'd0;
  int cyc = 0;
  int checks = 0;
  int errors = 0;

  logic a, b, c, busy, done, pass;
  logic [7:0] resp;
  logic [3:0] mm;
  logic o0;
  logic a1, b1, c1, busy1, done1, pass1;
  logic [7:0] resp1;
  logic [3:0] mm1;
  logic o1;

  exp_t q0[$];
  exp_t q1[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference circuit_5: o follows the golden truth table.
  always_comb begin
    o0 = GOLD[{a, b, c}];
    if (mode == 2'd1) o0 = 1'b0;
    if (mode == 2'd2) o0 = 1'b1;
    o1 = GOLD[{a1, b1, c1}];
  end

  circuit5_vector_driver #(.SETTLE_CYCLES(4), .GOLDEN(GOLD)) u_dut (
    .clk(clk), .rst(rst), .start(start), .o_in(o0),
    .a(a), .b(b), .c(c), .busy(busy), .done(done),
    .resp(resp), .pass(pass), .mismatch_cnt(mm)
  );

  circuit5_vector_driver #(.SETTLE_CYCLES(1), .GOLDEN(GOLD)) u_dut1 (
    .clk(clk), .rst(rst), .start(start1), .o_in(o1),
    .a(a1), .b(b1), .c(c1), .busy(busy1), .done(done1),
    .resp(resp1), .pass(pass1), .mismatch_cnt(mm1)
  );

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)",
               nm, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (done) begin
      checks++;
      if (q0.size() == 0) begin
        errors++;
        $display("FAIL dut0_spurious_done: got done expected none (cycle %0d)", cyc);
      end else begin
        e = q0.pop_front();
        check("dut0_done_cycle", cyc, e.cyc);
        check("dut0_resp", resp, e.resp);
        check("dut0_pass", pass, e.pass);
        check("dut0_mismatch", mm, e.mm);
      end
    end
    if (done1) begin
      checks++;
      if (q1.size() == 0) begin
        errors++;
        $display("FAIL dut1_spurious_done: got done expected none (cycle %0d)", cyc);
      end else begin
        e = q1.pop_front();
        check("dut1_done_cycle", cyc, e.cyc);
        check("dut1_resp", resp1, e.resp);
        check("dut1_pass", pass1, e.pass);
        check("dut1_mismatch", mm1, e.mm);
      end
    end
  end

  task automatic wait_to(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic start0(input logic [1:0] m, input logic [7:0] er,
                        input logic ep, input logic [3:0] emm,
                        output int k);
    mode = m;
    start = 1'b1;
    k = cyc + 1;
    q0.push_back('{er, ep, emm, k + 41});
    @(negedge clk);
    start = 1'b0;
  endtask

  initial begin
    int k;
    repeat (3) @(negedge clk);
    check("reset_dut0", {a, b, c, busy, done, resp, pass, mm}, 0);
    check("reset_dut1", {a1, b1, c1, busy1, done1, resp1, pass1, mm1}, 0);
    rst = 1'b0;
    @(negedge clk);

    // Sweep with a correct circuit_5
    start0(2'd0, 8'h51, 1'b1, 4'd0, k);
    check("t1_busy", busy, 1);
    for (int v = 0; v < 8; v++) begin
      wait_to(k + 5 * v + 2);
      check("t1_vector", {a, b, c}, v);
    end
    wait_to(k + 45);
    check("t1_missing_done", q0.size(), 0);
    check("t1_hold_abc", {a, b, c}, 3'b111);
    check("t1_idle_busy", busy, 0);
    check("t1_pass_held", pass, 1);

    // Stuck-at outputs
    start0(2'd1, 8'h00, 1'b0, 4'd3, k);
    wait_to(k + 45);
    check("t2_tie0_drain", q0.size(), 0);
    start0(2'd2, 8'hFF, 1'b0, 4'd5, k);
    wait_to(k + 45);
    check("t2_tie1_drain", q0.size(), 0);

    // Start while busy is ignored
    start0(2'd0, 8'h51, 1'b1, 4'd0, k);
    wait_to(k + 9);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_to(k + 55);
    check("t3_drain", q0.size(), 0);

    // Reset mid-sweep: no done, fresh sweep afterwards
    mode = 2'd0;
    start = 1'b1;
    k = cyc + 1;
    @(negedge clk);
    start = 1'b0;
    wait_to(k + 19);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("t4_busy", busy, 0);
    check("t4_abc", {a, b, c}, 0);
    check("t4_resp", resp, 0);
    wait_to(k + 60);
    start0(2'd0, 8'h51, 1'b1, 4'd0, k);
    wait_to(k + 45);
    check("t4_drain", q0.size(), 0);

    // SETTLE_CYCLES=1: each vector held exactly two cycles
    start1 = 1'b1;
    k = cyc + 1;
    q1.push_back('{8'h51, 1'b1, 4'd0, k + 17});
    @(negedge clk);
    start1 = 1'b0;
    for (int m = 0; m < 16; m++) begin
      wait_to(k + m);
      check("t5_vector", {a1, b1, c1}, m / 2);
    end
    wait_to(k + 22);
    check("t5_drain", q1.size(), 0);

    // start held high: back-to-back sweeps every 42 cycles
    mode = 2'd0;
    start = 1'b1;
    k = cyc + 1;
    for (int s = 0; s < 3; s++)
      q0.push_back('{8'h51, 1'b1, 4'd0, k + 41 + 42 * s});
    wait_to(k + 42);
    check("t6_resp_clear1", resp, 0);
    check("t6_busy1", busy, 1);
    wait_to(k + 84);
    check("t6_resp_clear2", resp, 0);
    wait_to(k + 125);
    start = 1'b0;
    wait_to(k + 135);
    check("t6_drain", q0.size(), 0);
    check("t6_idle", busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish (cycle %0d)", cyc);
    $fatal(1);
  end

endmodule
